// File: rtl/int_ctrl.sv
// Eight-line priority interrupt controller: synchronized rising-edge capture,
// maskable pending register, vector acknowledge with single-level in-service.
module int_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  irq_in,
  input  logic        CS,
  input  logic        write,
  input  logic [1:0]  adresse,
  input  logic [15:0] DATAout,
  output logic [15:0] DATAin,
  output logic [7:0]  Interrupts,
  output logic        irq
);

  typedef enum logic {
    IDLE  = 1'b0,
    INSVC = 1'b1
  } state_t;

  localparam logic [1:0] ADR_PEND   = 2'd0;
  localparam logic [1:0] ADR_MASK   = 2'd1;
  localparam logic [1:0] ADR_VECTOR = 2'd2;
  localparam logic [1:0] ADR_EOI    = 2'd3;

  state_t      state;
  logic [7:0]  sync_q [SYNC_STAGES];
  logic [7:0]  dly_q;
  logic [7:0]  edge_det;
  logic [7:0]  pend;
  logic [7:0]  mask;
  logic [7:0]  insvc;
  logic [7:0]  active;
  logic [7:0]  cand_oh;
  logic [2:0]  cand_idx;
  logic        cand_any;
  logic        valid;
  logic        rd_en;
  logic        wr_en;
  logic        ack;
  logic        eoi;
  logic [7:0]  w1c_clr;
  logic [7:0]  ack_clr;
  logic [15:0] rd_data;
  logic        unused_data_hi;

  assign unused_data_hi = ^DATAout[15:8];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      dly_q <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      dly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_q[SYNC_STAGES-1] & ~dly_q;

  // Walk from the top so the lowest-index active line is the one left standing.
  assign active = pend & mask;
  always_comb begin
    cand_idx = 3'd0;
    cand_oh  = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      if (active[i]) begin
        cand_idx = 3'(i);
        cand_oh  = 8'h01 << i;
      end
    end
  end

  assign cand_any = |active;
  assign valid    = cand_any && (state == IDLE);
  assign rd_en    = CS && !write;
  assign wr_en    = CS && write;
  assign ack      = rd_en && (adresse == ADR_VECTOR) && valid;
  assign eoi      = wr_en && (adresse == ADR_EOI);
  assign w1c_clr  = (wr_en && (adresse == ADR_PEND)) ? DATAout[7:0] : 8'h00;
  assign ack_clr  = ack ? cand_oh : 8'h00;

  always_comb begin
    rd_data = 16'h0000;
    case (adresse)
      ADR_PEND:   rd_data = {8'h00, pend};
      ADR_MASK:   rd_data = {8'h00, mask};
      ADR_VECTOR: rd_data = {valid, state == INSVC, 11'b0, valid ? cand_idx : 3'd0};
      ADR_EOI:    rd_data = {8'h00, insvc};
      default:    rd_data = 16'h0000;
    endcase
  end

  // New edges are OR-ed in last so a capture always beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pend       <= '0;
      mask       <= '0;
      insvc      <= '0;
      Interrupts <= '0;
      DATAin     <= '0;
    end else begin
      pend <= (pend & ~w1c_clr & ~ack_clr) | edge_det;

      if (wr_en && (adresse == ADR_MASK)) begin
        mask <= DATAout[7:0];
      end

      if (rd_en) begin
        DATAin <= rd_data;
      end

      case (state)
        IDLE: begin
          if (ack) begin
            state <= INSVC;
            insvc <= cand_oh;
          end
        end
        INSVC: begin
          if (eoi) begin
            state <= IDLE;
            insvc <= '0;
          end
        end
        default: begin
          state <= IDLE;
          insvc <= '0;
        end
      endcase

      // An acknowledged request drops right away rather than echoing one more cycle.
      Interrupts <= (valid && !ack) ? cand_oh : 8'h00;
    end
  end

  assign irq = |Interrupts;

endmodule
